// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
// Optional per-channel pop counters are compiled in with `define DEMUX_CNT_EN.
module demux1_2_buf #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic                 out_valid0,
    output logic                 out_valid1,
    input  logic                 out_ready0,
    input  logic                 out_ready1
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic [WIDTH-1:0] r_mem [2][2];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [1:0]       r_occ [2];

    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_out_ready;

    assign w_out_ready = {out_ready1, out_ready0};

    // Backpressure looks only at the selected channel's registered occupancy.
    assign in_ready = !flush && (r_occ[in_sel] != 2'd2);

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            w_pop[ch] = (r_occ[ch] != 2'd0) && w_out_ready[ch];
        end
        if (in_valid && in_ready) begin
            w_push[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_occ[ch]    <= '0;
                r_mem[ch][0] <= '0;
                r_mem[ch][1] <= '0;
            end
        end else if (flush) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_occ[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (w_push[ch]) begin
                    r_mem[ch][r_wp[ch]] <= in_data;
                    r_wp[ch]            <= ~r_wp[ch];
                end
                if (w_pop[ch]) begin
                    r_rp[ch] <= ~r_rp[ch];
                end
                case ({w_push[ch], w_pop[ch]})
                    2'b10:   r_occ[ch] <= r_occ[ch] + 2'd1;
                    2'b01:   r_occ[ch] <= r_occ[ch] - 2'd1;
                    default: r_occ[ch] <= r_occ[ch];
                endcase
            end
        end
    end

    assign out_valid0 = (r_occ[0] != 2'd0);
    assign out_valid1 = (r_occ[1] != 2'd0);
    assign out_data0  = r_mem[0][r_rp[0]];
    assign out_data1  = r_mem[1][r_rp[1]];

`ifdef DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt [2];

    // Counts every output handshake; only reset_n clears the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (w_pop[ch]) begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf: queue-based reference model plus directed vectors.
// Counter checks are active when DEMUX_CNT_EN is defined.
module tb_demux1_2_buf;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_data0, out_data1;
    logic             out_valid0, out_valid1;
    logic             out_ready0, out_ready1;
`ifdef DEMUX_CNT_EN
    logic [CW-1:0]    cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    demux1_2_buf #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel, counters as plain integers.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               mcnt0 = 0;
    int               mcnt1 = 0;

    function automatic bit model_ready();
        if (flush) return 1'b0;
        return in_sel ? (q1.size() < 2) : (q0.size() < 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            bit do_push, pop0, pop1;
            do_push = in_valid && model_ready();
            pop0    = out_ready0 && (q0.size() > 0);
            pop1    = out_ready1 && (q1.size() > 0);
            if (pop0) mcnt0 = (mcnt0 + 1) % (1 << CW);
            if (pop1) mcnt1 = (mcnt1 + 1) % (1 << CW);
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (pop0) void'(q0.pop_front());
                if (pop1) void'(q1.pop_front());
                if (do_push) begin
                    if (in_sel) q1.push_back(in_data);
                    else        q0.push_back(in_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_in_ready", 32'(in_ready), 32'(model_ready()));
        chk("m_valid0", 32'(out_valid0), 32'(q0.size() > 0));
        chk("m_valid1", 32'(out_valid1), 32'(q1.size() > 0));
        if (q0.size() > 0) chk("m_data0", 32'(out_data0), 32'(q0[0]));
        if (q1.size() > 0) chk("m_data1", 32'(out_data1), 32'(q1[0]));
`ifdef DEMUX_CNT_EN
        chk("m_cnt0", 32'(cnt0), 32'(mcnt0));
        chk("m_cnt1", 32'(cnt1), 32'(mcnt1));
`endif
    end

    // Drive inputs for one cycle, then step past the next rising edge.
    task automatic tick(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1, input logic f);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out_ready0 = r0;
        out_ready1 = r1;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        flush      = 1'b0;
        tick(0, 0, 8'h00, 0, 0, 0);
        tick(0, 0, 8'h00, 0, 0, 0);
        reset_n = 1'b1;
        tick(0, 0, 8'h00, 0, 0, 0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_data0", 32'(out_data0), 32'h00);

        // Routing, both consumers ready.
        tick(1, 0, 8'h11, 1, 1, 0);
        chk("route_v0", 32'(out_valid0), 32'd1);
        chk("route_d0a", 32'(out_data0), 32'h11);
        tick(1, 1, 8'h22, 1, 1, 0);
        chk("route_v0_gone", 32'(out_valid0), 32'd0);
        chk("route_d1", 32'(out_data1), 32'h22);
        tick(1, 0, 8'h33, 1, 1, 0);
        chk("route_d0b", 32'(out_data0), 32'h33);
        chk("route_v1_gone", 32'(out_valid1), 32'd0);
        tick(0, 0, 8'h00, 1, 1, 0);

        // Full channel 0 under backpressure; channel 1 keeps flowing.
        tick(1, 0, 8'hA1, 0, 0, 0);
        tick(1, 0, 8'hA2, 0, 0, 0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA3; #1;
        chk("full_rdy_sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1; #1;
        chk("full_rdy_sel1", 32'(in_ready), 32'd1);
        tick(1, 1, 8'hB1, 0, 0, 0);
        chk("bp_d1", 32'(out_data1), 32'hB1);
        chk("bp_head0", 32'(out_data0), 32'hA1);
        tick(1, 0, 8'hA3, 1, 0, 0);
        chk("bp_next0", 32'(out_data0), 32'hA2);
        tick(0, 0, 8'h00, 1, 1, 0);
        chk("bp_drained0", 32'(out_valid0), 32'd0);

        // Simultaneous push and pop on channel 0.
        tick(1, 0, 8'h01, 0, 0, 0);
        tick(1, 0, 8'h02, 1, 0, 0);
        chk("pp_data", 32'(out_data0), 32'h02);
        chk("pp_valid", 32'(out_valid0), 32'd1);
        tick(0, 0, 8'h00, 1, 0, 0);
        chk("pp_occ_one", 32'(out_valid0), 32'd0);

        // Flush with a word offered in the same cycle.
        tick(1, 0, 8'h55, 0, 0, 0);
        tick(1, 1, 8'h66, 0, 0, 0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77; flush = 1'b1; #1;
        chk("flush_rdy", 32'(in_ready), 32'd0);
        tick(1, 0, 8'h77, 0, 0, 1);
        chk("flush_v0", 32'(out_valid0), 32'd0);
        chk("flush_v1", 32'(out_valid1), 32'd0);
        tick(0, 0, 8'h00, 0, 0, 0);

        // Asynchronous reset with both FIFOs full.
        tick(1, 0, 8'hC1, 0, 0, 0);
        tick(1, 0, 8'hC2, 0, 0, 0);
        tick(1, 1, 8'hD1, 0, 0, 0);
        tick(1, 1, 8'hD2, 0, 0, 0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_v0", 32'(out_valid0), 32'd0);
        chk("arst_v1", 32'(out_valid1), 32'd0);
        chk("arst_d0", 32'(out_data0), 32'h00);
        chk("arst_d1", 32'(out_data1), 32'h00);
`ifdef DEMUX_CNT_EN
        chk("arst_cnt0", 32'(cnt0), 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(0, 0, 8'h00, 0, 0, 0);
        chk("arst_rdy", 32'(in_ready), 32'd1);

        // 17 pops on channel 1 at full throughput.
        for (int i = 0; i < 17; i++) begin
            tick(1, 1, 8'(i + 8'h40), 1'b0, 1'b1, 1'b0);
            chk("thru_v1", 32'(out_valid1), 32'd1);
            chk("thru_d1", 32'(out_data1), 32'(i + 8'h40));
        end
        tick(0, 0, 8'h00, 0, 1, 0);
        chk("thru_empty", 32'(out_valid1), 32'd0);
`ifdef DEMUX_CNT_EN
        chk("wrap_cnt1", 32'(cnt1), 32'd1);
        chk("wrap_cnt0", 32'(cnt0), 32'd0);
`endif
        tick(0, 0, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1_2_buf.md
# demux1_2_buf

Buffered 1-to-2 stream demultiplexer: the routing counterpart of the datapath 2:1 mux, steering one input stream to one of two output channels under a per-word select bit. Each output channel owns a 2-entry FIFO so a stalled consumer on one channel never corrupts in-flight data on the other. Sits between a single producer (e.g. a writeback/forwarding source) and two independent consumers in the pipelined datapath.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- CNT_WIDTH, 8, width of per-channel transfer counters (used only under DEMUX_CNT_EN)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle
- flush  input  1  synchronous clear of both FIFOs
- out_data0 / out_data1  output  WIDTH  head word of channel 0 / 1 FIFO
- out_valid0 / out_valid1  output  1  channel FIFO non-empty
- out_ready0 / out_ready1  input  1  consumer 0 / 1 takes head word
- cnt0 / cnt1  output  CNT_WIDTH  completed output transfers per channel (only with DEMUX_CNT_EN)

## Operation
- Push: in_valid && in_ready writes in_data into FIFO[in_sel] at its tail.
- in_ready = !flush && (occupancy[in_sel] < 2); combinational from in_sel, flush and registered occupancy only (no dependence on out_readyN).
- Pop: out_validN && out_readyN removes head of FIFO N; out_dataN then shows next entry (or holds stale value, don't-care, when empty).
- Each FIFO: 2 storage registers, 1-bit read and write pointers, 2-bit occupancy (0,1,2). Pointers wrap 1 -> 0.
- Occupancy update per channel: push only +1; pop only -1; push and pop same cycle: unchanged, data ordering preserved (head pops, new word lands at tail).
- Full (occupancy 2): in_ready low for words selecting that channel even if same-cycle pop; no bypass. Other channel unaffected.
- Empty: out_validN low; out_readyN ignored; no underflow.
- Per-channel ordering is strict FIFO; no ordering between channels.
- flush high: both FIFOs to occupancy 0, pointers 0 at next edge; same-cycle push and pops are discarded; in_ready low while flush high. Counters not cleared by flush.
- in_valid low: in_sel and in_data ignored.

## Timing
- Reset (reset_n low, asynchronous): occupancies 0, pointers 0, out_valid0/1 = 0, out_data0/1 = 0, cnt0/1 = 0; in_ready = 1 combinationally once reset_n high (empty FIFOs). Deassertion takes effect at next clk edge.
- Reset mid-operation discards all buffered words immediately.
- Latency: word pushed at edge k is visible on out_dataN with out_validN = 1 after edge k (1 cycle) if FIFO N was empty; otherwise after preceding entries pop.
- Throughput: 1 word/cycle per channel sustained when consumer ready every cycle.
- All outputs except in_ready are registered or driven from register state only.

## Configuration
- DEMUX_CNT_EN defined: cnt0/cnt1 ports present; cntN increments by 1 on every out_validN && out_readyN cycle, wraps 2^CNT_WIDTH-1 -> 0, reset to 0 only by reset_n.
- DEMUX_CNT_EN undefined: cnt0/cnt1 ports and counter logic absent; CNT_WIDTH unused; all other behaviour identical.

## Test plan
- Reset: drive reset_n=0 mid-stream with both FIFOs full -> out_valid0/1=0, out_data0/1=0, cnt0/1=0 immediately; in_ready=1 after release.
- Routing: push 0x11 sel0, 0x22 sel1, 0x33 sel0 with both consumers ready -> channel 0 outputs 0x11 then 0x33, channel 1 outputs 0x22, each 1 cycle after push.
- Full/backpressure: out_ready0=0, push 0xA1,0xA2 sel0 -> occupancy 2, in_ready=0 for sel0, in_ready=1 for sel1; push 0xB1 sel1 accepted; release out_ready0 -> 0xA1, 0xA2 in order.
- Simultaneous push/pop: FIFO0 holding 0x01, out_ready0=1 and push 0x02 sel0 same cycle -> occupancy stays 1, out_data0=0x02 next cycle.
- Flush: both FIFOs holding data, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid0/1=0, pushed word dropped, counters unchanged.
- Counter wrap (DEMUX_CNT_EN, CNT_WIDTH=4): 17 pops on channel 1 -> cnt1=1, cnt0=0.
